uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Configurable UART receiver, next generation of the fixed-format receiver FSM.
//  - Frame format is selectable at run time: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
//  - Adds an input synchroniser, 3-sample majority voting, false-start rejection, framing/break detection
//    and a valid/ready output with overrun flag.
//  - Sits between the baud-tick generator (s_ticks) and the host-side consumer.
// PARAMETERS
//  DATA_W       8   max data bits; m_data width (>=5)
//  OVS          16  s_ticks per bit period (even, >=8)
//  SYNC_STAGES  2   rx synchroniser flops (>=2)
// PORTS
//  clk             in   1       clock; all logic rises on posedge
//  Reset           in   1       synchronous, active-high reset
//  s_ticks         in   1       oversample strobe, 1 clk wide, OVS per bit
//  rx              in   1       serial line, idle high, async
//  cfg_data_bits   in   4       data bits per frame, 5..DATA_W (others -> DATA_W)
//  cfg_parity_en   in   1       1 = parity bit present
//  cfg_parity_odd  in   1       1 = odd, 0 = even
//  cfg_stop2       in   1       1 = two stop bits
//  m_valid         out  1       output word held
//  m_ready         in   1       consumer accepts when m_valid&&m_ready
//  m_data          out  DATA_W  received data, LSB first on line, unused MSBs 0
//  m_parity_err    out  1       parity mismatch for held word
//  m_frame_err     out  1       a stop bit sampled 0 for held word
//  m_break         out  1       held word is a break condition
//  overrun         out  1       1-clk pulse: completed frame dropped
// BEHAVIOUR
//  Reset: state IDLE, synchroniser all 1, counters 0; m_valid, m_data, all flags, overrun = 0.
//   Reset mid-frame aborts the frame; nothing is output.
//  rx passes SYNC_STAGES flops -> rxs; every decision uses rxs only.
//  Tick counter: $clog2(OVS) bits, advances on s_ticks, wraps at OVS-1.
//  Bit value = 2-of-3 majority of rxs at ticks OVS/2-1, OVS/2, OVS/2+1; decided at OVS/2+1.
//  cfg_* are latched on start detect; changes mid-frame have no effect until the next frame.
//  FSM:
//   IDLE: rxs falling (prev 1, now 0) -> START, tick=0.
//   START: majority 1 at OVS/2+1 -> IDLE (false start, no output); else at OVS-1 -> DATA, n=0.
//   DATA: per bit, shift majority into bit n (LSB first); at OVS-1 of bit cfg_data_bits-1
//    -> PARITY if enabled, else STOP.
//   PARITY: even: error if XOR(data,bit)!=0; odd: error if XOR!=1; at OVS-1 -> STOP.
//   STOP: each stop bit majority 0 sets frame_err.
//    - 1st of 2 stops: at OVS-1 -> 2nd stop.
//    - Last stop: commit at OVS/2+1, then -> IDLE, or -> BRK_WAIT if break.
//   BRK_WAIT: stay until rxs==1, then IDLE (no new start from the held-low line).
//  Break = all data bits 0 AND parity bit 0 (if enabled) AND first stop bit 0.
//   Also sets m_frame_err; m_data=0.
//  Commit (1 clk after the deciding s_ticks), with output state:
//   m_valid=0                 -> load data+flags, m_valid=1.
//   m_valid=1, m_ready=1      -> same-cycle handoff: load new word, m_valid stays 1, no overrun.
//   m_valid=1, m_ready=0      -> drop new frame, held word unchanged, overrun=1 for 1 clk.
//  No commit and m_valid&&m_ready -> m_valid=0; data/flags hold their last value.
//  Latency: rx falling edge -> START entry = SYNC_STAGES+1 clk.
//   m_data/m_valid stable while m_valid && !m_ready.
// TESTING (DATA_W=8, OVS=16, SYNC_STAGES=2)
//  8N1 send 0xA5, m_ready=1 -> one m_valid beat, m_data=0xA5, all flags 0.
//  7E1 send 0x35 with parity bit forced 1 -> m_data=0x35, m_parity_err=1, frame_err=0.
//  5O2 send 0x1B, 2nd stop bit 0 -> m_data=0x1B, m_frame_err=1, m_break=0.
//  rx low for 4 ticks then high, 8N1 -> no m_valid, FSM back in IDLE; next 0x3C received correctly.
//  rx low 12 bit-times, 8N1 -> exactly one word: m_break=1, m_frame_err=1, m_data=0x00;
//   next frame 0x55 after rx high is received.
//  Back-to-back 0x11, 0x22, m_ready=0 -> m_data=0x11 kept, overrun pulses once.
//   Repeat with m_ready=1 on the commit cycle -> 0x22 loaded, no overrun.
//  Reset for 1 clk mid-DATA -> m_valid stays 0; following frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: run-time frame format, synchronised input, 3-sample majority voting,
// false-start rejection, framing/break detection and a valid/ready output holding register.
module uart_rx_cfg #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              s_ticks,
    input  logic              rx,
    input  logic [3:0]        cfg_data_bits,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_stop2,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_parity_err,
    output logic              m_frame_err,
    output logic              m_break,
    output logic              overrun
);
    localparam int unsigned TW = $clog2(OVS);
    localparam int unsigned IW = $clog2(DATA_W);

    localparam logic [TW-1:0] TickLast = TW'(OVS - 1);
    localparam logic [TW-1:0] TickS0   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TickS1   = TW'(OVS / 2);
    localparam logic [TW-1:0] TickS2   = TW'(OVS / 2 + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrkWait} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs_prev_q, rxs_prev_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [1:0]             smp_q, smp_d;
    logic [IW-1:0]          bit_q, bit_d;
    logic [IW-1:0]          last_q, last_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   stop2_q, stop2_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;

    logic                   m_valid_q, m_valid_d;
    logic [DATA_W-1:0]      m_data_q, m_data_d;
    logic                   m_perr_q, m_perr_d;
    logic                   m_ferr_q, m_ferr_d;
    logic                   m_brk_q, m_brk_d;
    logic                   overrun_q, overrun_d;

    logic rxs;
    logic maj;
    logic at_mid;
    logic at_last;
    logic commit;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign at_mid  = s_ticks && (tick_q == TickS2);
    assign at_last = s_ticks && (tick_q == TickLast);
    // Third vote is taken live on the deciding tick.
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
        rxs_prev_d = rxs;
        state_d    = state_q;
        tick_d     = tick_q;
        smp_d      = smp_q;
        bit_d      = bit_q;
        last_d     = last_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        par_bit_d  = par_bit_q;
        stop_idx_d = stop_idx_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        commit     = 1'b0;

        if (s_ticks) begin
            tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
            if (tick_q == TickS0) smp_d[0] = rxs;
            if (tick_q == TickS1) smp_d[1] = rxs;
        end

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                if (rxs_prev_q && !rxs) begin
                    state_d    = StStart;
                    bit_d      = '0;
                    shift_d    = '0;
                    par_bit_d  = 1'b0;
                    stop_idx_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    brk_d      = 1'b0;
                    par_en_d   = cfg_parity_en;
                    par_odd_d  = cfg_parity_odd;
                    stop2_d    = cfg_stop2;
                    if (cfg_data_bits >= 4'd5 && 32'(cfg_data_bits) <= DATA_W) begin
                        last_d = IW'(cfg_data_bits - 4'd1);
                    end else begin
                        last_d = IW'(DATA_W - 1);
                    end
                end
            end
            StStart: begin
                if (at_mid && maj) begin
                    state_d = StIdle;
                end else if (at_last) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (at_mid) shift_d[bit_q] = maj;
                if (at_last) begin
                    if (bit_q == last_q) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (at_mid) begin
                    par_bit_d = maj;
                    perr_d    = ((^shift_q) ^ maj) != par_odd_q;
                end
                if (at_last) state_d = StStop;
            end
            StStop: begin
                if (at_mid) begin
                    if (!maj) ferr_d = 1'b1;
                    if (!stop_idx_q) begin
                        brk_d = (shift_q == '0) && !(par_en_q && par_bit_q) && !maj;
                    end
                    if (stop_idx_q || !stop2_q) begin
                        commit  = 1'b1;
                        state_d = brk_d ? StBrkWait : StIdle;
                    end
                end
                if (at_last) stop_idx_d = 1'b1;
            end
            StBrkWait: begin
                // Held-low line must return high before a new start can be seen.
                if (rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_perr_d  = m_perr_q;
        m_ferr_d  = m_ferr_q;
        m_brk_d   = m_brk_q;
        overrun_d = 1'b0;
        if (commit) begin
            if (!m_valid_q || m_ready) begin
                m_valid_d = 1'b1;
                m_data_d  = shift_q;
                m_perr_d  = perr_d;
                m_ferr_d  = ferr_d;
                m_brk_d   = brk_d;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
            tick_q     <= '0;
            smp_q      <= '0;
            bit_q      <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_perr_q   <= 1'b0;
            m_ferr_q   <= 1'b0;
            m_brk_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rxs_prev_q <= rxs_prev_d;
            tick_q     <= tick_d;
            smp_q      <= smp_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            par_bit_q  <= par_bit_d;
            stop_idx_q <= stop_idx_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_perr_q   <= m_perr_d;
            m_ferr_q   <= m_ferr_d;
            m_brk_q    <= m_brk_d;
            overrun_q  <= overrun_d;
        end
    end

    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_parity_err = m_perr_q;
    assign m_frame_err  = m_ferr_q;
    assign m_break      = m_brk_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: serialises frames onto rx, records every accepted output word and
// compares against a frame-level reference model.
module tb_uart_rx_cfg;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned OVS         = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TDIV        = 4;
    localparam int unsigned BIT_CLKS    = OVS * TDIV;
    // Index of the s_ticks (counted from START entry) on which an 8N1 frame commits.
    localparam int unsigned COMMIT_J    = 9 * OVS + OVS / 2 + 1;

    logic              clk = 1'b0;
    logic              Reset;
    logic              s_ticks;
    logic              rx;
    logic [3:0]        cfg_data_bits;
    logic              cfg_parity_en;
    logic              cfg_parity_odd;
    logic              cfg_stop2;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_parity_err;
    logic              m_frame_err;
    logic              m_break;
    logic              overrun;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ovr_cnt = 0;
    logic [10:0] got[$];

    uart_rx_cfg #(
        .DATA_W      (DATA_W),
        .OVS         (OVS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .s_ticks        (s_ticks),
        .rx             (rx),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_parity_err   (m_parity_err),
        .m_frame_err    (m_frame_err),
        .m_break        (m_break),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    initial begin : ticker
        int unsigned div;
        div = 0;
        s_ticks = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_ticks = (div == 0);
            div = (div + 1) % TDIV;
        end
    end

    always @(negedge clk) begin
        if (!Reset) begin
            if (m_valid && m_ready) got.push_back({m_break, m_frame_err, m_parity_err, m_data});
            if (overrun) ovr_cnt <= ovr_cnt + 1;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic int eff_bits(input logic [3:0] b);
        return (b >= 4'd5 && b <= 4'd8) ? int'(b) : 8;
    endfunction

    // Expected {break, frame_err, parity_err, data} for the bits actually put on the line.
    function automatic logic [10:0] ref_word(input logic [7:0] data, input int nb, input bit pe,
                                             input bit po, input bit pbit, input bit two,
                                             input bit s1, input bit s2);
        logic [7:0] d;
        bit perr, ferr, brk;
        d    = data & (8'hFF >> (8 - nb));
        perr = pe && (((^d) ^ pbit) != po);
        ferr = !s1 || (two && !s2);
        brk  = (d == 8'h00) && !(pe && pbit) && !s1;
        return {brk, ferr, perr, d};
    endfunction

    task automatic drive_bit(input bit b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [3:0] bits, input bit pe,
                              input bit po, input bit two, input bit flip, input bit s1,
                              input bit s2, input bit scramble, output bit pbit);
        int nb;
        logic [7:0] d;
        nb = eff_bits(bits);
        d = data & (8'hFF >> (8 - nb));
        pbit = (^d) ^ po ^ flip;
        cfg_data_bits  = bits;
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_stop2      = two;
        repeat ($urandom_range(8, 40)) @(posedge clk);
        #1;
        drive_bit(1'b0);
        if (scramble) begin
            cfg_data_bits  = 4'($urandom_range(0, 15));
            cfg_parity_en  = 1'($urandom_range(0, 1));
            cfg_parity_odd = 1'($urandom_range(0, 1));
            cfg_stop2      = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < nb; i++) drive_bit(data[i]);
        if (pe) drive_bit(pbit);
        drive_bit(s1);
        if (two) drive_bit(s2);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        rx = 1'b1;
        m_ready = 1'b1;
        cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({m_valid, m_data, m_parity_err, m_frame_err, m_break, overrun} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h pe=%b fe=%b brk=%b ovr=%b want all 0",
                     m_valid, m_data, m_parity_err, m_frame_err, m_break, overrun);
        end
        Reset = 1'b0;
        settle();
    endtask

    task automatic test_8n1();
        bit pb;
        int base;
        got.delete();
        base = ovr_cnt;
        send_frame(8'hA5, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
        settle();
        n_cmp++;
        if (got.size() != 1) begin
            n_err++;
            $display("FAIL 8n1_beats: got %0d want 1", got.size());
        end
        if (got.size() > 0) begin
            n_cmp++;
            if (got[0] !== {3'b000, 8'hA5}) begin
                n_err++;
                $display("FAIL 8n1_word: got %h want %h", got[0], {3'b000, 8'hA5});
            end
        end
        n_cmp++;
        if (ovr_cnt != base) begin
            n_err++;
            $display("FAIL 8n1_overrun: got %0d pulses want 0", ovr_cnt - base);
        end
    endtask

    task automatic test_parity_err();
        bit pb;
        got.delete();
        send_frame(8'h35, 4'd7, 1, 0, 0, 1, 1, 1, 0, pb);
        settle();
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b001, 8'h35}) begin
            n_err++;
            $display("FAIL 7e1_parity: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b001, 8'h35});
        end
    endtask

    task automatic test_frame_err();
        bit pb;
        got.delete();
        send_frame(8'h1B, 4'd5, 1, 1, 1, 0, 1, 0, 0, pb);
        settle();
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b010, 8'h1B}) begin
            n_err++;
            $display("FAIL 5o2_frame: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b010, 8'h1B});
        end
    endtask

    task automatic test_false_start();
        bit pb;
        got.delete();
        cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_stop2 = 1'b0;
        rx = 1'b0;
        repeat (4 * TDIV) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3) settle();
        n_cmp++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL false_start_out: got %0d words want 0", got.size());
        end
        send_frame(8'h3C, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
        settle();
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b000, 8'h3C}) begin
            n_err++;
            $display("FAIL false_start_next: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b000, 8'h3C});
        end
    endtask

    task automatic test_break();
        bit pb;
        got.delete();
        cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_stop2 = 1'b0;
        rx = 1'b0;
        repeat (12 * BIT_CLKS) @(posedge clk);
        #1;
        rx = 1'b1;
        settle();
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b110, 8'h00}) begin
            n_err++;
            $display("FAIL break_word: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b110, 8'h00});
        end
        got.delete();
        send_frame(8'h55, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
        settle();
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b000, 8'h55}) begin
            n_err++;
            $display("FAIL break_next: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b000, 8'h55});
        end
    endtask

    task automatic test_back_to_back();
        bit pb;
        bit done;
        int base;
        int changes;
        // Overrun: second frame dropped while first is held.
        got.delete();
        m_ready = 1'b0;
        base = ovr_cnt;
        send_frame(8'h11, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
        done = 1'b0;
        changes = 0;
        fork
            begin
                send_frame(8'h22, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (m_valid !== 1'b1 || m_data !== 8'h11) changes++;
                end
            end
        join
        settle();
        n_cmp++;
        if (changes != 0) begin
            n_err++;
            $display("FAIL b2b_hold_stable: got %0d unstable cycles want 0", changes);
        end
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            n_err++;
            $display("FAIL b2b_held: got valid=%b data=%h want valid=1 data=11", m_valid, m_data);
        end
        n_cmp++;
        if (ovr_cnt - base != 1) begin
            n_err++;
            $display("FAIL b2b_overrun: got %0d pulse cycles want 1", ovr_cnt - base);
        end
        m_ready = 1'b1;
        settle();
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b000, 8'h11}) begin
            n_err++;
            $display("FAIL b2b_drain: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b000, 8'h11});
        end

        // Handoff: consumer accepts on the very cycle the next frame commits.
        got.delete();
        m_ready = 1'b0;
        send_frame(8'h11, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
        base = ovr_cnt;
        fork
            send_frame(8'h22, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
            begin
                int cnt;
                cnt = 0;
                @(negedge rx);
                repeat (SYNC_STAGES + 1) @(posedge clk);
                while (cnt < COMMIT_J) begin
                    @(negedge clk);
                    if (s_ticks) cnt++;
                end
                repeat (TDIV) @(posedge clk);
                #1;
                m_ready = 1'b1;
                @(posedge clk);
                #1;
                m_ready = 1'b0;
            end
        join
        settle();
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h22) begin
            n_err++;
            $display("FAIL handoff_load: got valid=%b data=%h want valid=1 data=22", m_valid, m_data);
        end
        n_cmp++;
        if (ovr_cnt != base) begin
            n_err++;
            $display("FAIL handoff_overrun: got %0d pulses want 0", ovr_cnt - base);
        end
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b000, 8'h11}) begin
            n_err++;
            $display("FAIL handoff_accept: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b000, 8'h11});
        end
        got.delete();
        m_ready = 1'b1;
        settle();
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b000, 8'h22}) begin
            n_err++;
            $display("FAIL handoff_drain: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b000, 8'h22});
        end
    endtask

    task automatic test_reset_mid_frame();
        bit pb;
        got.delete();
        m_ready = 1'b0;
        send_frame(8'h5A, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
        fork
            send_frame(8'hFF, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
            begin
                repeat (BIT_CLKS * 3 + BIT_CLKS / 2) @(posedge clk);
                #1;
                Reset = 1'b1;
                @(posedge clk);
                #1;
                Reset = 1'b0;
            end
        join
        n_cmp++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid_clear: got valid=%b data=%h want valid=0 data=00", m_valid, m_data);
        end
        m_ready = 1'b1;
        settle();
        n_cmp++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_no_word: got %0d words want 0", got.size());
        end
        send_frame(8'h7E, 4'd8, 0, 0, 0, 0, 1, 1, 0, pb);
        settle();
        n_cmp++;
        if (got.size() != 1 || got[0] !== {3'b000, 8'h7E}) begin
            n_err++;
            $display("FAIL rst_mid_next: got n=%0d w=%h want n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {3'b000, 8'h7E});
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [3:0]  b;
        bit          pe, po, two, flip, scr, pb;
        logic [10:0] exp;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d    = 8'($urandom);
            b    = 4'($urandom_range(0, 15));
            pe   = 1'($urandom_range(0, 1));
            po   = 1'($urandom_range(0, 1));
            two  = 1'($urandom_range(0, 1));
            flip = 1'($urandom_range(0, 1));
            scr  = 1'($urandom_range(0, 1));
            got.delete();
            send_frame(d, b, pe, po, two, flip, 1, 1, scr, pb);
            settle();
            exp = ref_word(d, eff_bits(b), pe, po, pb, two, 1'b1, 1'b1);
            n_cmp++;
            if (got.size() != 1) begin
                n_err++;
                $display("FAIL random_beats[%0d]: got %0d want 1", i, got.size());
            end else begin
                n_cmp++;
                if (got[0] !== exp) begin
                    n_err++;
                    $display("FAIL random_word[%0d]: got %h want %h (bits=%0d pe=%b po=%b two=%b)",
                             i, got[0], exp, b, pe, po, two);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_err();
        test_frame_err();
        test_false_start();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
